// File: rtl/fht_pkg.sv
// Shared definitions for the 8-point row FHT: sizes, read FSM states and the
// sign-extension helper used by the butterfly datapath.
package fht_pkg;

    localparam int FHT_POINTS = 8;
    localparam int FHT_IDX_W  = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } rd_state_e;

    // Sign-extend the low w bits of v to the full 32 bits.
    function automatic logic [31:0] fht_sext(input logic [31:0] v, input int w);
        logic [31:0] r;
        logic [4:0]  msb;
        msb = 5'(w - 1);
        r   = v;
        for (int i = 0; i < 32; i++) begin
            if (i >= w) begin
                r[i] = v[msb];
            end else begin
                r[i] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_row_butterfly_if.sv
// Sample-in / result-out stream bundle of the row butterfly stage.
interface fht_row_butterfly_if #(
    parameter int N = 8
);
    logic         valid;
    logic [N-1:0] a;
    logic [N:0]   p;
    logic         p_valid;
    logic         p_last;
    logic         p_first;

    modport master (
        output valid, a,
        input  p, p_valid, p_last, p_first
    );

    modport slave (
        input  valid, a,
        output p, p_valid, p_last, p_first
    );
endinterface

// File: rtl/fht_bfly_bank.sv
// One 8 x N sample bank: single write port, paired combinational reads of
// entries j and j+4 for the butterfly.
module fht_bfly_bank
    import fht_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 we,
    input  logic [FHT_IDX_W-1:0] widx,
    input  logic [N-1:0]         wdata,
    input  logic [1:0]           ridx,
    output logic [N-1:0]         rd_lo,
    output logic [N-1:0]         rd_hi
);

    logic [N-1:0] mem_r [FHT_POINTS];

    // Sample storage; cleared on reset so the bank never holds X.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < FHT_POINTS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[widx] <= wdata;
        end
    end

    assign rd_lo = mem_r[{1'b0, ridx}];
    assign rd_hi = mem_r[{1'b1, ridx}];

endmodule

// File: rtl/fht_row_butterfly.sv
// First radix-2 butterfly stage of the 8-point row FHT: ping-pong row capture
// and one N+1-bit result per cycle. FHT_BFLY_SCALE_EN halves every result.
module fht_row_butterfly
    import fht_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rstn,
    fht_row_butterfly_if.slave  bus
);

    logic [FHT_IDX_W-1:0] wcnt_r;
    logic                 wsel_r;
    logic                 start_s;

    rd_state_e            state_r, state_nxt_s;
    logic [FHT_IDX_W-1:0] rcnt_r, rcnt_nxt_s;
    logic                 rsel_r, rsel_nxt_s;

    logic [N-1:0]         ping_lo_s, ping_hi_s, pong_lo_s, pong_hi_s;
    logic [N-1:0]         rd_lo_s, rd_hi_s;
    logic [31:0]          lo_ext32_s, hi_ext32_s;
    logic [N:0]           lo_ext_s, hi_ext_s;
    logic [N:0]           res_s, out_s;

    logic [N:0]           p_r;
    logic                 p_valid_r, p_first_r, p_last_r;

    // The last sample of a row starts emission straight away so result 0 is
    // registered on the very next edge.
    assign start_s = bus.valid && (wcnt_r == 3'd7);

    // Write counter and bank select; gaps in valid simply hold them.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wcnt_r <= 3'd0;
            wsel_r <= 1'b0;
        end else if (bus.valid) begin
            wcnt_r <= wcnt_r + 3'd1;
            if (wcnt_r == 3'd7) begin
                wsel_r <= ~wsel_r;
            end else begin
                wsel_r <= wsel_r;
            end
        end else begin
            wcnt_r <= wcnt_r;
            wsel_r <= wsel_r;
        end
    end

    fht_bfly_bank #(.N(N)) u_ping (
        .clk   (clk),
        .rstn  (rstn),
        .we    (bus.valid && !wsel_r),
        .widx  (wcnt_r),
        .wdata (bus.a),
        .ridx  (rcnt_r[1:0]),
        .rd_lo (ping_lo_s),
        .rd_hi (ping_hi_s)
    );

    fht_bfly_bank #(.N(N)) u_pong (
        .clk   (clk),
        .rstn  (rstn),
        .we    (bus.valid && wsel_r),
        .widx  (wcnt_r),
        .wdata (bus.a),
        .ridx  (rcnt_r[1:0]),
        .rd_lo (pong_lo_s),
        .rd_hi (pong_hi_s)
    );

    // Read FSM state, result index and bank under emission.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_r <= IDLE;
            rcnt_r  <= 3'd0;
            rsel_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            rcnt_r  <= rcnt_nxt_s;
            rsel_r  <= rsel_nxt_s;
        end
    end

    // Next-state logic; a start on the final result chains the next row
    // without a bubble.
    always_comb begin
        state_nxt_s = state_r;
        rcnt_nxt_s  = rcnt_r;
        rsel_nxt_s  = rsel_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = EMIT;
                    rcnt_nxt_s  = 3'd0;
                    rsel_nxt_s  = wsel_r;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EMIT: begin
                if (rcnt_r == 3'd7) begin
                    rcnt_nxt_s = 3'd0;
                    if (start_s) begin
                        state_nxt_s = EMIT;
                        rsel_nxt_s  = wsel_r;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    rcnt_nxt_s = rcnt_r + 3'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                rcnt_nxt_s  = 3'd0;
            end
        endcase
    end

    assign rd_lo_s    = rsel_r ? pong_lo_s : ping_lo_s;
    assign rd_hi_s    = rsel_r ? pong_hi_s : ping_hi_s;
    assign lo_ext32_s = fht_sext(32'(rd_lo_s), N);
    assign hi_ext32_s = fht_sext(32'(rd_hi_s), N);
    assign lo_ext_s   = lo_ext32_s[N:0];
    assign hi_ext_s   = hi_ext32_s[N:0];

    // Butterfly: sums for j=0..3, differences x[j-4]-x[j] for j=4..7;
    // both fit exactly in N+1 bits.
    always_comb begin
        res_s = '0;
        if (rcnt_r[2]) begin
            res_s = lo_ext_s - hi_ext_s;
        end else begin
            res_s = lo_ext_s + hi_ext_s;
        end
`ifdef FHT_BFLY_SCALE_EN
        out_s = {res_s[N], res_s[N:1]};
`else
        out_s = res_s;
`endif
    end

    // Registered result and framing flags; zero outside emission.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            p_r       <= '0;
            p_valid_r <= 1'b0;
            p_first_r <= 1'b0;
            p_last_r  <= 1'b0;
        end else if (state_r == EMIT) begin
            p_r       <= out_s;
            p_valid_r <= 1'b1;
            p_first_r <= (rcnt_r == 3'd0);
            p_last_r  <= (rcnt_r == 3'd7);
        end else begin
            p_r       <= '0;
            p_valid_r <= 1'b0;
            p_first_r <= 1'b0;
            p_last_r  <= 1'b0;
        end
    end

    assign bus.p       = p_r;
    assign bus.p_valid = p_valid_r;
    assign bus.p_first = p_first_r;
    assign bus.p_last  = p_last_r;

endmodule

// File: tb/tb_fht_row_butterfly.sv
// Directed bench for fht_row_butterfly (N=8); expected rows are hand-computed
// for both the default and the FHT_BFLY_SCALE_EN build.
module tb_fht_row_butterfly;

    logic clk;
    logic rstn;
    int   cyc;
    int   cmp_cnt;
    int   err_cnt;

    typedef struct {
        int v;
        int f;
        int l;
        int c;
    } exp_t;

    exp_t exp_q[$];

    fht_row_butterfly_if #(.N(8)) bus ();

    fht_row_butterfly #(.N(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: every p_valid cycle must match the next queued result,
    // and a queued result whose cycle has come must not be missing.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            if (bus.p_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("p", $signed(bus.p), e.v);
                    chk("p_first", int'(bus.p_first), e.f);
                    chk("p_last", int'(bus.p_last), e.l);
                    chk("p_cycle", cyc, e.c);
                end
            end else if (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_valid", 0, 1);
            end
        end
    end

    task automatic send_row(input int x[8], input int e[8], input int gap);
        int   v;
        int   last_e;
        exp_t t;
        for (int i = 0; i < 8; i++) begin
            v         = x[i];
            bus.valid = 1'b1;
            bus.a     = v[7:0];
            @(posedge clk);
            #1;
            bus.valid = 1'b0;
            if (i < 7) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        last_e = cyc;
        for (int j = 0; j < 8; j++) begin
            t.v = e[j];
            t.f = (j == 0) ? 1 : 0;
            t.l = (j == 7) ? 1 : 0;
            t.c = last_e + 1 + j;
            exp_q.push_back(t);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_p"}, $signed(bus.p), 0);
        chk({tag, "_p_valid"}, int'(bus.p_valid), 0);
        chk({tag, "_p_first"}, int'(bus.p_first), 0);
        chk({tag, "_p_last"}, int'(bus.p_last), 0);
    endtask

    int row_a[8], exp_a[8];
    int row_b[8], exp_b[8];
    int row_c[8], exp_c[8];
    int row_m[8], exp_m[8];
    int row_n[8], exp_n[8];
    int row_d0[8], exp_d0[8];
    int row_d1[8], exp_d1[8];
    int part[8];

    initial begin
        cyc       = 0;
        cmp_cnt   = 0;
        err_cnt   = 0;
        bus.valid = 1'b0;
        bus.a     = '0;
        rstn      = 1'b1;

        row_a  = '{1, 2, 3, 4, 5, 6, 7, 8};
        row_b  = '{10, -20, 30, -40, 5, 6, -7, 8};
        row_c  = '{-1, -2, -3, -4, -5, -6, -7, -8};
        row_m  = '{-128, -128, -128, -128, -128, -128, -128, -128};
        row_n  = '{127, 127, 127, 127, -128, -128, -128, -128};
        row_d0 = '{1, 0, 0, 0, 0, 0, 0, 0};
        row_d1 = '{0, 0, 0, 0, 1, 0, 0, 0};
        part   = '{9, 9, 9, 9, 9, 9, 9, 9};
`ifdef FHT_BFLY_SCALE_EN
        exp_a  = '{3, 4, 5, 6, -2, -2, -2, -2};
        exp_b  = '{7, -7, 11, -16, 2, -13, 18, -24};
        exp_c  = '{-3, -4, -5, -6, 2, 2, 2, 2};
        exp_m  = '{-128, -128, -128, -128, 0, 0, 0, 0};
        exp_n  = '{-1, -1, -1, -1, 127, 127, 127, 127};
        exp_d0 = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_d1 = '{0, 0, 0, 0, -1, 0, 0, 0};
`else
        exp_a  = '{6, 8, 10, 12, -4, -4, -4, -4};
        exp_b  = '{15, -14, 23, -32, 5, -26, 37, -48};
        exp_c  = '{-6, -8, -10, -12, 4, 4, 4, 4};
        exp_m  = '{-256, -256, -256, -256, 0, 0, 0, 0};
        exp_n  = '{-1, -1, -1, -1, 255, 255, 255, 255};
        exp_d0 = '{1, 0, 0, 0, 1, 0, 0, 0};
        exp_d1 = '{1, 0, 0, 0, -1, 0, 0, 0};
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rstn = 1'b0;
        @(posedge clk);
        #1;

        // Single row, then extremes and the rounding corner rows
        send_row(row_a, exp_a, 0);
        wait_drain();
        send_row(row_m, exp_m, 0);
        wait_drain();
        send_row(row_n, exp_n, 0);
        wait_drain();
        send_row(row_d0, exp_d0, 0);
        wait_drain();
        send_row(row_d1, exp_d1, 0);
        wait_drain();

        // Three back-to-back rows: queued cycles enforce 24 contiguous results
        send_row(row_b, exp_b, 0);
        send_row(row_c, exp_c, 0);
        send_row(row_a, exp_a, 0);
        wait_drain();

        // Valid on every third cycle
        send_row(row_a, exp_a, 2);
        wait_drain();

        // Reset in the middle of a row: the partial row must vanish
        for (int i = 0; i < 5; i++) begin
            bus.valid = 1'b1;
            bus.a     = 8'(part[i]);
            @(posedge clk);
            #1;
        end
        bus.valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrst1");
        @(negedge clk);
        chk_idle_outputs("midrst2");
        rstn = 1'b0;
        @(posedge clk);
        #1;
        send_row(row_a, exp_a, 0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fht_row_butterfly.md
# fht_row_butterfly

First radix-2 butterfly stage of the 8-point row FHT. It collects a serial row of eight signed N-bit samples into a ping-pong buffer. It then streams out the eight stage-1 butterfly results, one per cycle, at N+1 bits. Its output stream feeds the second butterfly stage and the constant sqrt(2) multiplier path.

## Interface
- N, default 8: input sample width, two's complement.
- clk  input  1  rising-edge clock.
- rstn  input  1  reset; asynchronous, active-high. The name follows codebase convention; the polarity is high.
- valid  input  1  qualifies `a` this cycle.
- a  input  N  input sample, signed.
- p  output  N+1  butterfly result, signed, registered.
- p_valid  output  1  qualifies `p`.
- p_last  output  1  high with the 8th result of a row.
- p_first  output  1  high with the 1st result of a row.

## Operation
- **Write side**
  - 3-bit write counter `wcnt`. Each cycle with `valid` high writes `a` into bank `wsel`, entry `wcnt`, then increments `wcnt`.
  - On the sample with `wcnt==7`: `wcnt` wraps to 0, `wsel` toggles, and the filled bank is handed to the read side (`rsel <= wsel`, read start pulse).
- **Valid gaps**: samples need not be contiguous. Gaps in `valid` stall `wcnt` only.
- **Read FSM**: states IDLE and EMIT.
  - IDLE -> EMIT on the read start pulse, with `rcnt=0`.
  - In EMIT, each cycle produces result `rcnt`, then increments `rcnt`.
  - EMIT -> IDLE after `rcnt==7` when no new start is pending.
  - EMIT -> EMIT with `rcnt=0` on the other bank when a start pulse coincides with `rcnt==7`. This gives back-to-back rows with no bubble.
- **Results** (x = stored row of bank `rsel`):
  - j = 0..3: p = x[j] + x[j+4].
  - j = 4..7: p = x[j-4] − x[j].
- **Arithmetic**: operands are sign-extended to N+1 before add/subtract. The result is exact at N+1 bits, so no overflow is possible.
- **Rate**: the input rate is at most 1 sample/cycle, and a row takes exactly 8 emit cycles. The bank being read is therefore never the bank being written, and no overrun logic is required.
- **Simultaneous events**:
  - A write into bank B in the same cycle as a read of bank A is legal.
  - A start pulse while EMIT is at `rcnt<7` cannot occur; it would need more than 1 sample/cycle.
- **Reset mid-operation**: a partial input row is discarded and any emission in progress is aborted. After release, the next valid sample is sample 0 of a new row, written to bank 0.

## Timing
- **Reset values**: p=0, p_valid=0, p_first=0, p_last=0, wcnt=0, rcnt=0, wsel=0, FSM=IDLE. Bank contents are don't-care.
- **Latency**: the 8th sample of a row is captured at edge E. Result 0 appears on `p` with `p_valid=1` and `p_first=1` after edge E+1. Result 7 appears after edge E+8 with `p_last=1`.
- `p_valid` stays high for exactly 8 consecutive cycles per row.
- With continuous input (valid high every cycle), `p_valid` stays high continuously from the first row's E+1.
- There is no backpressure; the downstream stage must accept one result per cycle.

## Configuration
- **FHT_BFLY_SCALE_EN**
  - Defined: each result is arithmetically shifted right by 1 (floor) before registering, then sign-extended back to N+1 bits. The block-level gain is 1/2, which prevents growth across later stages.
  - Undefined: exact N+1-bit sum/difference as described above.
- Latency and handshake are identical in both builds.

## Structure
- Shared package `fht_pkg`:
  - FHT_POINTS = 8.
  - FHT_IDX_W = 3.
  - Read FSM state enum (IDLE, EMIT).
  - Sign-extension helper function.
- Sub-module `fht_bfly_bank`: one 8×N register bank with one write port and two combinational read ports (index j and j+4). It is instantiated twice, for the ping and pong banks.
- The top level holds the counters, the FSM, the add/subtract and the output registers.

## Test plan
- **Single row**: after reset, send a = 1,2,3,4,5,6,7,8 contiguously. Expect p = 6,8,10,12,−4,−4,−4,−4, starting 1 cycle after the 8th sample. Expect `p_first` on 6 and `p_last` on the final −4.
- **Extremes, N=8**: send row x[0..3] = −128, x[4..7] = −128. Expect sums = −256 and diffs = 0. Send x[0..3] = 127, x[4..7] = −128. Expect sums = −1 and diffs = 255.
- **Back-to-back**: send three rows continuously. Expect 24 contiguous `p_valid` cycles with no bubble, correct values per row, and `p_first`/`p_last` every 8 cycles.
- **Gapped input**: apply `valid` on every third cycle for one row. Expect output to start exactly 1 cycle after the 8th accepted sample, with values identical to the contiguous case.
- **Reset mid-row**: send 5 samples, assert `rstn` for 2 cycles, then send a full row 1..8. Expect all outputs at 0 during reset and exactly one row of results: 6,8,10,12,−4,−4,−4,−4.
- **Scale build** (FHT_BFLY_SCALE_EN defined): single-row stimulus 1..8. Expect p = 3,4,5,6,−2,−2,−2,−2. Row x[0] = 1, x[4] = 0: diff_0 = 1 gives 0, and row x[0] = 0, x[4] = 1: diff_0 = −1 gives −1.
